// File: rtl/dbf_scan_ctrl.sv
// Scanline sequencer for a digital beamformer: per line it loads the delay LUT,
// fires the transmit burst, then opens the receive window. Optional abort input
// is compiled in with the DBF_SCAN_ABORT_EN macro.
module dbf_scan_ctrl #(
  parameter int ADDR_WD   = 10,
  parameter int LUT_DEPTH = 1024,
  parameter int TX_CYCLES = 64,
  parameter int RX_CYCLES = 2048
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef DBF_SCAN_ABORT_EN
  input  logic               abort,
`endif
  input  logic               scan_req,
  input  logic [7:0]         num_lines,
  output logic               busy,
  output logic               frame_done,
  output logic [ADDR_WD-1:0] dbf_lut_addr,
  output logic               dbf_lut_we,
  output logic               tx_en,
  output logic               start,
  output logic [7:0]         line_idx,
  output logic [2:0]         dbg_state
);

  localparam int MAX_LT  = (LUT_DEPTH > TX_CYCLES) ? LUT_DEPTH : TX_CYCLES;
  localparam int MAX_CYC = (MAX_LT > RX_CYCLES) ? MAX_LT : RX_CYCLES;
  // Counter doubles as the LUT address, so it is never narrower than ADDR_WD.
  localparam int CNT_WD  = ($clog2(MAX_CYC + 1) > ADDR_WD) ? $clog2(MAX_CYC + 1) : ADDR_WD;

  localparam logic [CNT_WD-1:0] LOAD_LAST = CNT_WD'(LUT_DEPTH - 1);
  localparam logic [CNT_WD-1:0] TX_LAST   = CNT_WD'(TX_CYCLES - 1);
  localparam logic [CNT_WD-1:0] RX_LAST   = CNT_WD'(RX_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, TX, RX, NEXT} state_e;

  state_e              state_q, state_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic [7:0]          line_idx_q, line_idx_d;
  logic [7:0]          lines_q, lines_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [ADDR_WD-1:0]  addr_q, addr_d;
  logic                we_q, we_d;
  logic                tx_en_q, tx_en_d;
  logic                start_q, start_d;
  logic                abort_w;
  logic                last_line;

`ifdef DBF_SCAN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign last_line = (line_idx_q == lines_q - 8'd1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_idx_d   = line_idx_q;
    lines_d      = lines_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_req && (num_lines != 8'd0)) begin
          state_d    = LOAD;
          lines_d    = num_lines;
          line_idx_d = 8'd0;
          cnt_d      = '0;
        end
      end
      LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = TX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX: begin
        if (cnt_q == TX_LAST) begin
          state_d = RX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX: begin
        if (cnt_q == RX_LAST) begin
          state_d      = NEXT;
          cnt_d        = '0;
          // frame_done is a registered output, so it is raised on entry to NEXT.
          frame_done_d = last_line;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NEXT: begin
        if (last_line) begin
          state_d = IDLE;
        end else begin
          state_d    = LOAD;
          line_idx_d = line_idx_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_w && (state_q != IDLE)) begin
      state_d      = IDLE;
      cnt_d        = '0;
      frame_done_d = 1'b1;
    end
    busy_d  = (state_d != IDLE);
    we_d    = (state_d == LOAD);
    tx_en_d = (state_d == TX);
    start_d = (state_d == RX);
    addr_d  = we_d ? cnt_d[ADDR_WD-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_idx_q   <= 8'd0;
      lines_q      <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      tx_en_q      <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_idx_q   <= line_idx_d;
      lines_q      <= lines_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      tx_en_q      <= tx_en_d;
      start_q      <= start_d;
    end
  end

  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign dbf_lut_addr = addr_q;
  assign dbf_lut_we   = we_q;
  assign tx_en        = tx_en_q;
  assign start        = start_q;
  assign line_idx     = line_idx_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dbf_scan_ctrl.sv
// Bench for dbf_scan_ctrl: a frame model pushes expected per-cycle output
// vectors; a monitor pops one whenever the DUT shows any activity.
module tb_dbf_scan_ctrl;
  localparam int ADDR_WD = 10;
  localparam int LUT_D   = 4;
  localparam int TX_C    = 4;
  localparam int RX_C    = 8;
  localparam int W       = 23;

  logic               clk;
  logic               rst_n;
  logic               scan_req;
  logic [7:0]         num_lines;
  logic               abort;
  logic               busy, frame_done, dbf_lut_we, tx_en, start;
  logic [ADDR_WD-1:0] dbf_lut_addr;
  logic [7:0]         line_idx;
  logic [2:0]         dbg_state;

  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  dbf_scan_ctrl #(
    .ADDR_WD(ADDR_WD), .LUT_DEPTH(LUT_D), .TX_CYCLES(TX_C), .RX_CYCLES(RX_C)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef DBF_SCAN_ABORT_EN
    .abort(abort),
`endif
    .scan_req(scan_req),
    .num_lines(num_lines),
    .busy(busy),
    .frame_done(frame_done),
    .dbf_lut_addr(dbf_lut_addr),
    .dbf_lut_we(dbf_lut_we),
    .tx_en(tx_en),
    .start(start),
    .line_idx(line_idx),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] vec(input logic b, input logic we, input logic tx,
                                       input logic st, input logic fd,
                                       input logic [7:0] ln, input logic [9:0] ad);
    return {b, we, tx, st, fd, ln, ad};
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {busy, dbf_lut_we, tx_en, start, frame_done, line_idx, dbf_lut_addr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame of n lines, each LUT load, TX burst, RX window, one gap cycle.
  task automatic push_frame(input int n);
    for (int l = 0; l < n; l++) begin
      for (int a = 0; a < LUT_D; a++) exp_q.push_back(vec(1, 1, 0, 0, 0, 8'(l), 10'(a)));
      for (int t = 0; t < TX_C; t++)  exp_q.push_back(vec(1, 0, 1, 0, 0, 8'(l), 10'd0));
      for (int r = 0; r < RX_C; r++)  exp_q.push_back(vec(1, 0, 0, 1, 0, 8'(l), 10'd0));
      exp_q.push_back(vec(1, 0, 0, 0, (l == n - 1), 8'(l), 10'd0));
    end
  endtask

  // A request starts a frame only when nothing is in flight and n is nonzero.
  task automatic issue(input logic [7:0] n);
    @(negedge clk);
    scan_req  = 1'b1;
    num_lines = n;
    if (n != 8'd0 && exp_q.size() == 0) push_frame(int'(n));
    @(posedge clk);
    #1 scan_req = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 2000) begin
      @(posedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d outputs still expected, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(name, {27'd0, busy, dbf_lut_we, tx_en, start, frame_done}, 32'd0);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && (busy || dbf_lut_we || tx_en || start || frame_done)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got %h required idle at %0t", act_vec(), $time);
      end else begin
        check("cycle_vector", 32'(act_vec()), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if ((32'(tx_en) + 32'(start) + 32'(dbf_lut_we)) > 1) begin
        miscompares++;
        $display("FAIL exclusive: tx_en=%b start=%b we=%b required at most one",
                 tx_en, start, dbf_lut_we);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    scan_req    = 1'b0;
    num_lines   = 8'd0;
    abort       = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", 32'(act_vec()), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    check_idle("idle_after_reset", 3);

    // single and multi-line frames
    issue(8'd1);
    drain();
    issue(8'd3);
    drain();

    // zero-line request is ignored
    issue(8'd0);
    check_idle("zero_lines", 4);

    // request during RX must not start a second frame
    issue(8'd2);
    repeat (10) @(posedge clk);
    issue(8'd5);
    drain();
    check_idle("no_queued_frame", 20);

    // reset during TX cycle 2
    issue(8'd2);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_tx", 32'(act_vec()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check_idle("idle_after_mid_reset", 8);

`ifdef DBF_SCAN_ABORT_EN
    issue(8'd1);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    exp_q.delete();
    exp_q.push_back(vec(1, 1, 0, 0, 0, 8'd0, 10'd2));
    exp_q.push_back(vec(0, 0, 0, 0, 1, 8'd0, 10'd0));
    @(posedge clk);
    #1 abort = 1'b0;
    drain();
    @(negedge clk) abort = 1'b1;
    check_idle("abort_in_idle", 3);
    abort = 1'b0;
`else
    issue(8'd1);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    drain();
`endif

    // randomized frames
    for (int k = 0; k < 6; k++) begin
      issue(8'($urandom_range(0, 4)));
      drain();
      check_idle("idle_between_frames", 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
